mux2_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared 2-way, 5-bit select mux, e.g. a register-address path feeding one register-file port.
- Decides each cycle which requester owns the mux and drives the mux address (`sel`).
- Moves the winning beat into a registered output stage using valid/ready handshakes.
- Round-robin fairness with a bounded hold (burst) window per owner.

---
 rtl/mux_arb_pkg.sv | 25 ++
 rtl/arb_hold_counter.sv | 53 +++++
 rtl/mux2.sv | 19 +
 rtl/mux2_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mux2_port_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Brief    : Shared types and constants for the two-port mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT0     = 1'b0;
    localparam logic PORT1     = 1'b1;
    localparam int   WIDTH_DEF = 5;
    localparam int   HOLD_W    = 4;

    function automatic arb_state_t own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_hold_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_hold_counter
// Brief    : Burst-length counter for the current mux owner, saturating at
//            MAX_HOLD; at_limit flags an exhausted hold window.
// Revision : 1.0 - initial release
// ============================================================================
module arb_hold_counter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              transfer,
    input  logic              same_owner,
    input  logic              clear,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              at_limit
);

    localparam logic [HOLD_W-1:0] C_MAX_HOLD = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    assign at_limit = (hold_cnt_q == C_MAX_HOLD);
    assign hold_cnt = hold_cnt_q;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (transfer) begin
            // A new owner always starts its burst at one beat.
            if (!same_owner) begin
                hold_cnt_d = HOLD_W'(1);
            end else if (!at_limit) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end else if (clear) begin
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
// Module   : mux2
// Brief    : Generic 2-way data multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
module mux2 #(
    parameter int WIDTH = 5
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule
`default_nettype wire

// File: rtl/mux2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_port_arbiter
// Brief    : Round-robin arbiter with bounded burst hold for a shared 2-way
//            mux; registered output stage with valid/ready handshakes.
//            Optional grant statistics when ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_port_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
`ifdef ARB_STATS_EN
    input  logic             clr_stats,
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1,
`endif
    output logic             busy
);

    arb_state_t        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;

    logic              gnt;
    logic              any_valid;
    logic              load;
    logic              transfer;
    logic              same_owner;
    logic              at_limit;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WIDTH-1:0]  mux_data;

    assign any_valid  = req0_valid | req1_valid;
    assign load       = !out_valid_q | out_ready;
    assign transfer   = load & any_valid;
    assign req0_ready = transfer & (gnt == PORT0);
    assign req1_ready = transfer & (gnt == PORT1);
    assign same_owner = ((state_q == OWN0) && (gnt == PORT0)) ||
                        ((state_q == OWN1) && (gnt == PORT1));

    // The owner keeps the mux unless its hold window is spent and the other side waits.
    always_comb begin
        gnt = PORT0;
        case (state_q)
            OWN0: begin
                if (req0_valid && !(at_limit && req1_valid)) begin
                    gnt = PORT0;
                end else if (req1_valid) begin
                    gnt = PORT1;
                end
            end
            OWN1: begin
                if (req1_valid && !(at_limit && req0_valid)) begin
                    gnt = PORT1;
                end else if (req0_valid) begin
                    gnt = PORT0;
                end else begin
                    gnt = PORT1;
                end
            end
            default: begin
                if (req0_valid && req1_valid) begin
                    gnt = ~last_q;
                end else begin
                    gnt = req1_valid ? PORT1 : PORT0;
                end
            end
        endcase
    end

    mux2 #(
        .WIDTH (WIDTH)
    ) u_payload_mux (
        .i_sel (gnt),
        .i_d0  (req0_data),
        .i_d1  (req1_data),
        .o_y   (mux_data)
    );

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .transfer   (transfer),
        .same_owner (same_owner),
        .clear      (load & !any_valid),
        .hold_cnt   (hold_cnt),
        .at_limit   (at_limit)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sel_d       = sel_q;
        last_d      = last_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            sel_d       = gnt;
            last_d      = gnt;
            state_d     = own_state(gnt);
        end else if (load) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (clr_stats) begin
            gnt_cnt0_d = '0;
            gnt_cnt1_d = '0;
        end else begin
            if (req0_ready && (gnt_cnt0_q != 16'hFFFF)) begin
                gnt_cnt0_d = gnt_cnt0_q + 16'd1;
            end
            if (req1_ready && (gnt_cnt1_q != 16'hFFFF)) begin
                gnt_cnt1_d = gnt_cnt1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_port_arbiter
// Brief    : Directed self-checking bench for mux2_port_arbiter (MAX_HOLD=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_port_arbiter;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;
    logic             busy;
`ifdef ARB_STATS_EN
    logic             clr_stats;
    logic [15:0]      gnt_cnt0, gnt_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_gnt [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    mux2_port_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
`ifdef ARB_STATS_EN
        .clr_stats  (clr_stats),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1),
`endif
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b1;
`ifdef ARB_STATS_EN
        clr_stats  = 1'b0;
`endif
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_sel",       32'(sel),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // Single request from req0
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 5'h0A;
        #1;
        check("t1_req0_ready", 32'(req0_ready), 32'd1);
        check("t1_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data",  32'(out_data),  32'h0A);
        check("t1_sel",       32'(sel),       32'd0);
        check("t1_busy",      32'(busy),      32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        check("t1_idle_busy",  32'(busy),      32'd0);

        // Both valid after reset: blocks of four
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 5'h03;
        req1_valid = 1'b1;
        req1_data  = 5'h1C;
        for (int i = 0; i < 9; i++) begin
            #1;
            check("t2_req0_ready", 32'(req0_ready), (exp_gnt[i] == 0) ? 32'd1 : 32'd0);
            check("t2_req1_ready", 32'(req1_ready), (exp_gnt[i] == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            check("t2_sel",      32'(sel),      32'(exp_gnt[i]));
            check("t2_out_data", 32'(out_data), (exp_gnt[i] == 1) ? 32'h1C : 32'h03);
            @(negedge clk);
        end

        // Back-pressure for three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_req0_ready", 32'(req0_ready), 32'd0);
            check("t3_req1_ready", 32'(req1_ready), 32'd0);
            @(posedge clk); #1;
            check("t3_out_valid", 32'(out_valid), 32'd1);
            check("t3_out_data",  32'(out_data),  32'h03);
            check("t3_sel",       32'(sel),       32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("t3_resume_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        check("t3_resume_sel",  32'(sel),          32'd0);
        check("t3_resume_hold", 32'(dut.hold_cnt), 32'd2);

        // req1 alone for ten beats, then req0 joins
        @(negedge clk);
        req0_valid = 1'b0;
        req1_data  = 5'h15;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t4_req1_ready", 32'(req1_ready), 32'd1);
            @(posedge clk); #1;
            check("t4_sel",      32'(sel),          32'd1);
            check("t4_out_data", 32'(out_data),     32'h15);
            check("t4_hold_cnt", 32'(dut.hold_cnt), (i < 3) ? 32'(i + 1) : 32'd4);
            @(negedge clk);
        end
        req0_valid = 1'b1;
        req0_data  = 5'h07;
        #1;
        check("t4_switch_ready0", 32'(req0_ready), 32'd1);
        check("t4_switch_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check("t4_switch_sel",  32'(sel),          32'd0);
        check("t4_switch_data", 32'(out_data),     32'h07);
        check("t4_switch_hold", 32'(dut.hold_cnt), 32'd1);

        // Asynchronous reset mid-burst
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_sel",   32'(sel),       32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_tie_ready0", 32'(req0_ready), 32'd1);
        check("t5_tie_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check("t5_tie_sel",  32'(sel),      32'd0);
        check("t5_tie_data", 32'(out_data), 32'h07);
        check("t5_tie_busy", 32'(busy),     32'd1);

        // Both drop: back to IDLE
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("idle_ready0", 32'(req0_ready), 32'd0);
        check("idle_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_busy",      32'(busy),      32'd0);

`ifdef ARB_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cnt0", 32'(gnt_cnt0), 32'd0);
        check("t6_rst_cnt1", 32'(gnt_cnt1), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        repeat (5) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("t6_cnt0", 32'(gnt_cnt0), 32'd5);
        check("t6_cnt1", 32'(gnt_cnt1), 32'd3);
        @(negedge clk);
        clr_stats  = 1'b1;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        check("t6_clr_cnt0", 32'(gnt_cnt0), 32'd0);
        check("t6_clr_cnt1", 32'(gnt_cnt1), 32'd0);
        @(negedge clk);
        clr_stats = 1'b0;
        @(posedge clk); #1;
        check("t6_post_cnt0", 32'(gnt_cnt0), 32'd1);
        check("t6_post_cnt1", 32'(gnt_cnt1), 32'd0);
        req0_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
